// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: one state register plus a memory wait
// counter; every datapath select/enable is decoded combinationally from state.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_byte,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_op,
  output logic [3:0] state,
  output logic       trap
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB   = 4'd4,  S_MEM_WR = 4'd5,  S_R_EXEC   = 4'd6, S_R_WB   = 4'd7,
    S_BRANCH   = 4'd8,  S_JUMP   = 4'd9,  S_I_EXEC   = 4'd10, S_I_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000, OP_SB   = 6'b101000, OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101, OP_BLEZ = 6'b000110, OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_BGEZ  = 6'b000001, OP_J    = 6'b000010, OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ADDIU= 6'b001001, OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101, OP_XORI = 6'b001110, OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111, FN_JR   = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_LUI = 4'd6, ALU_FUNCT = 4'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                    return S_R_EXEC;
      OP_LW, OP_SW, OP_LB, OP_SB:                  return S_MEM_ADDR;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ:   return S_BRANCH;
      OP_J, OP_JAL:                                return S_JUMP;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLTI, OP_LUI:                             return S_I_EXEC;
      default:                                     return S_TRAP;
    endcase
  endfunction

  function automatic logic [3:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_SLTI: return ALU_SLT;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [5:0] op, input logic z, input logic n);
    case (op)
      OP_BEQ:  return z;
      OP_BNE:  return !z;
      OP_BLEZ: return n | z;
      OP_BGTZ: return !n && !z;
      OP_BGEZ: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Next state and wait counter; ready is checked before the limit so ready wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_MEM_RD: state_d = S_MEM_WB;
            default:  state_d = S_FETCH;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE:   state_d = decode_next(opcode);
      S_MEM_ADDR: state_d = (opcode == OP_LW || opcode == OP_LB) ? S_MEM_RD : S_MEM_WR;
      S_R_EXEC:   state_d = (funct == FN_JR) ? S_FETCH : S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_TRAP:     state_d = S_TRAP;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
      default:    state_d = S_TRAP;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to zero while rst_n is low so nothing fires during reset.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_byte   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    imm_zext   = 1'b0;
    alu_op     = ALU_ADD;
    trap       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'd3;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mem_byte = (opcode == OP_LB);
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          mem_byte  = (opcode == OP_SB);
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          if (funct == FN_JR) begin
            pc_write = 1'b1;
            pc_src   = 2'd3;
          end
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'd1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'd1;
          pc_write  = branch_taken(opcode, zero, neg);
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = i_alu_op(opcode);
          imm_zext  = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI);
        end
        S_I_WB: begin
          reg_write = 1'b1;
          alu_op    = i_alu_op(opcode);
          imm_zext  = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI);
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: Fetch, Decode, Execute, Memory and Writeback are spread over several clocks, so one ALU and one unified memory port are shared across cycles.
- Decodes opcode/funct from the instruction register and drives every datapath select and enable on each cycle.
- Handshakes with the memory port and traps on illegal opcodes or memory timeouts.
- Sits between the IR and the datapath muxes, the register file and the memory interface.

Parameters:
- WAIT_LIMIT, 16: maximum cycles to wait for mem_ready in a memory state before trapping.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- neg  in  1  ALU result bit 31.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 0 ALU result (PC+4), 1 ALUOut (branch target), 2 jump target {PC[31:28],IR[25:0],00}, 3 register rs (jr).
- ir_write  out  1  load IR.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_byte  out  1  byte access (lb/sb).
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  destination register: 0 rt, 1 rd, 2 $31.
- mem_to_reg  out  2  write-back data source: 0 ALUOut, 1 MDR, 2 PC.
- alu_src_a  out  1  ALU operand A: 0 PC, 1 rs.
- alu_src_b  out  2  ALU operand B: 0 rt, 1 constant 4, 2 sign-extended imm, 3 sign-extended imm<<2.
- imm_zext  out  1  zero-extend imm instead of sign-extend (andi/ori/xori).
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 LUI, 7 use funct.
- state  out  4  current state, for debug.
- trap  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH, wait counter=0, trap=0.
- During reset every enable (pc_write, ir_write, mem_read, mem_write, reg_write) is 0 and every select is 0.
- All outputs are Moore outputs decoded from state (plus opcode/funct/zero/neg where listed). No output is registered beyond the state register itself.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (precomputes the branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC.
  - 100011, 101011, 100000, 101000 -> MEM_ADDR.
  - 000100, 000101, 000110, 000111, 000001 -> BRANCH.
  - 000010, 000011 -> JUMP.
  - 001000, 001001, 001100, 001101, 001110, 001010, 001111 -> I_EXEC.
  - Any other opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Loads (100011, 100000) -> MEM_RD; stores -> MEM_WR.
- MEM_RD: mem_read=1, iord=1, mem_byte=1 for lb. On mem_ready go to MEM_WB.
- MEM_WR: mem_write=1, iord=1, mem_byte=1 for sb. On mem_ready go to FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=7.
  - funct 001000 (jr): pc_write=1, pc_src=3, then FETCH.
  - Otherwise go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1. pc_write=1 only when the condition holds; then FETCH. Conditions:
  - beq: zero.
  - bne: !zero.
  - blez: neg|zero.
  - bgtz: !neg&!zero.
  - bgez: !neg.
- JUMP: pc_write=1, pc_src=2. For jal also reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2.
  - alu_op: addi/addiu ADD, andi AND, ori OR, xori XOR, slti SLT, lui LUI.
  - imm_zext=1 for andi/ori/xori.
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, with the same alu_op/imm_zext as I_EXEC. Then FETCH.
- Wait counter:
  - Cleared on entry to any memory state (FETCH, MEM_RD, MEM_WR).
  - Increments each cycle mem_ready=0 in that state.
  - If it reaches WAIT_LIMIT with mem_ready still 0, go to TRAP; no pc_write or reg_write occurs.
- TRAP: all enables 0 and trap=1. The FSM stays in TRAP until rst_n is asserted low.
- mem_ready outside a memory state is ignored.
- An access that has mem_ready=1 on the same cycle the counter reaches WAIT_LIMIT completes normally (ready wins).
- Reset asserted mid-instruction aborts it immediately. No partial write is guaranteed beyond the cycle reset falls.

Test Plan:
- add (opcode 0, funct 100000), mem_ready=1 every cycle -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in state 7; 4 cycles total.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> 0(x4),1,2,3(x4),4,0; ir_write pulses exactly once; reg_write with mem_to_reg=1 only in state 4.
- Branches, each from state 8:
  - beq with zero=1 -> pc_write=1, pc_src=1.
  - bne with zero=1 -> pc_write=0.
  - bgtz with neg=0, zero=0 -> pc_write=1.
- jal -> state 9: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. jr (funct 001000) in state 6 -> pc_src=3, and R_WB is skipped.
- Illegal opcode 111111 -> TRAP after DECODE, trap=1, no enables. mem_ready held 0 for WAIT_LIMIT cycles in MEM_WR -> TRAP with mem_write never completing.
- rst_n pulsed low mid-MEM_RD (asynchronous, between edges) -> state=0 and all enables 0 immediately; the next fetch proceeds normally once rst_n is released.
